// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the pipeline control carrier.
//   ctrl_t       : per-instruction EX/M/WB control bundle as produced by the decoder.
//   CtrlBubble   : all-zero bundle; never writes memory or the register file.
//   Fwd*         : ALU operand source selects driven by the forwarding unit.
package ctrl_pipe_pkg;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       reg_src;
      logic       reg_write;
   } ctrl_t;

   localparam ctrl_t CtrlBubble = '0;

   localparam logic [1:0] FwdNone = 2'b00;
   localparam logic [1:0] FwdWb   = 2'b01;
   localparam logic [1:0] FwdMem  = 2'b10;

endpackage

// File: rtl/ctrl_pipe_fwd_unit.sv
// EX-stage operand forwarding compare (purely combinational).
//   mem_reg_write/mem_wreg : writer currently in MEM
//   wb_reg_write/wb_wreg   : writer currently in WB
//   ex_rs/ex_rt            : source specifiers of the instruction in EX
//   fwd_a/fwd_b            : operand source selects (FwdNone/FwdWb/FwdMem)
module ctrl_pipe_fwd_unit
   import ctrl_pipe_pkg::*;
#(
   parameter int unsigned REG_W = 5
) (
   input  logic             mem_reg_write,
   input  logic [REG_W-1:0] mem_wreg,
   input  logic             wb_reg_write,
   input  logic [REG_W-1:0] wb_wreg,
   input  logic [REG_W-1:0] ex_rs,
   input  logic [REG_W-1:0] ex_rt,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
);

   // MEM holds the younger result, so it wins over WB. $0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
      if (mem_reg_write && (mem_wreg != '0) && (mem_wreg == src)) begin
         return FwdMem;
      end else if (wb_reg_write && (wb_wreg != '0) && (wb_wreg == src)) begin
         return FwdWb;
      end
      return FwdNone;
   endfunction

   always_comb begin
      fwd_a = fwd_sel(ex_rs);
      fwd_b = fwd_sel(ex_rt);
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline control carrier for the five-stage MIPS core.
// Carries the decoder's control bundle through ID/EX, EX/MEM and MEM/WB, detects
// load-use hazards (stall + bubble), squashes wrong-path work on a branch taken in
// MEM, and drives the EX-stage forwarding selects.
//   id_*            : decoder bundle and register fields of the instruction in ID
//   mem_zero        : registered ALU zero flag of the instruction in MEM
//   ex_*/mem_*/wb_* : per-stage control outputs
//   pc_write, ifid_write : 0 freezes PC and IF/ID
//   pc_src, ifid_flush   : branch target select and IF/ID clear
//   fwd_a, fwd_b         : ALU operand source selects
module ctrl_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int unsigned REG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic             id_reg_dst,
   input  logic             id_alu_src,
   input  logic             id_branch,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             id_reg_src,
   input  logic             id_reg_write,
   input  logic [1:0]       id_alu_op,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             mem_zero,
   output logic             ex_alu_src,
   output logic             ex_reg_dst,
   output logic [1:0]       ex_alu_op,
   output logic [REG_W-1:0] ex_rs,
   output logic [REG_W-1:0] ex_rt,
   output logic             mem_mem_read,
   output logic             mem_mem_write,
   output logic             mem_branch,
   output logic             wb_reg_src,
   output logic             wb_reg_write,
   output logic [REG_W-1:0] wb_wreg,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             pc_src,
   output logic             ifid_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
);

   // ID/EX
   ctrl_t            ex_ctrl_q, ex_ctrl_d;
   logic [REG_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
   // EX/MEM
   logic             mem_mem_read_q, mem_mem_read_d, mem_mem_write_q, mem_mem_write_d;
   logic             mem_branch_q, mem_branch_d, mem_reg_src_q, mem_reg_src_d;
   logic             mem_reg_write_q, mem_reg_write_d;
   logic [REG_W-1:0] mem_wreg_q, mem_wreg_d;
   // MEM/WB
   logic             wb_reg_src_q, wb_reg_src_d, wb_reg_write_q, wb_reg_write_d;
   logic [REG_W-1:0] wb_wreg_q, wb_wreg_d;

   logic stall, taken;

   always_comb begin
      stall = id_valid & ex_ctrl_q.mem_read & (ex_rt_q != '0) &
              ((ex_rt_q == id_rs) | (ex_rt_q == id_rt));
      taken = mem_branch_q & mem_zero;

      // A taken branch discards the stalled instruction anyway, so never freeze then.
      pc_write   = ~stall | taken;
      ifid_write = ~stall | taken;
      pc_src     = taken;
      ifid_flush = taken;

      if (taken || stall || !id_valid) begin
         ex_ctrl_d = CtrlBubble;
         ex_rs_d   = '0;
         ex_rt_d   = '0;
         ex_rd_d   = '0;
      end else begin
         ex_ctrl_d = '{reg_dst:   id_reg_dst,
                       alu_src:   id_alu_src,
                       alu_op:    id_alu_op,
                       branch:    id_branch,
                       mem_read:  id_mem_read,
                       mem_write: id_mem_write,
                       reg_src:   id_reg_src,
                       reg_write: id_reg_write};
         ex_rs_d   = id_rs;
         ex_rt_d   = id_rt;
         ex_rd_d   = id_rd;
      end

      if (taken) begin
         mem_mem_read_d  = 1'b0;
         mem_mem_write_d = 1'b0;
         mem_branch_d    = 1'b0;
         mem_reg_src_d   = 1'b0;
         mem_reg_write_d = 1'b0;
         mem_wreg_d      = '0;
      end else begin
         mem_mem_read_d  = ex_ctrl_q.mem_read;
         mem_mem_write_d = ex_ctrl_q.mem_write;
         mem_branch_d    = ex_ctrl_q.branch;
         mem_reg_src_d   = ex_ctrl_q.reg_src;
         mem_reg_write_d = ex_ctrl_q.reg_write;
         mem_wreg_d      = ex_ctrl_q.reg_dst ? ex_rd_q : ex_rt_q;
      end

      // The branch itself writes nothing, so MEM/WB always advances.
      wb_reg_src_d   = mem_reg_src_q;
      wb_reg_write_d = mem_reg_write_q;
      wb_wreg_d      = mem_wreg_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_ctrl_q       <= CtrlBubble;
         ex_rs_q         <= '0;
         ex_rt_q         <= '0;
         ex_rd_q         <= '0;
         mem_mem_read_q  <= 1'b0;
         mem_mem_write_q <= 1'b0;
         mem_branch_q    <= 1'b0;
         mem_reg_src_q   <= 1'b0;
         mem_reg_write_q <= 1'b0;
         mem_wreg_q      <= '0;
         wb_reg_src_q    <= 1'b0;
         wb_reg_write_q  <= 1'b0;
         wb_wreg_q       <= '0;
      end else begin
         ex_ctrl_q       <= ex_ctrl_d;
         ex_rs_q         <= ex_rs_d;
         ex_rt_q         <= ex_rt_d;
         ex_rd_q         <= ex_rd_d;
         mem_mem_read_q  <= mem_mem_read_d;
         mem_mem_write_q <= mem_mem_write_d;
         mem_branch_q    <= mem_branch_d;
         mem_reg_src_q   <= mem_reg_src_d;
         mem_reg_write_q <= mem_reg_write_d;
         mem_wreg_q      <= mem_wreg_d;
         wb_reg_src_q    <= wb_reg_src_d;
         wb_reg_write_q  <= wb_reg_write_d;
         wb_wreg_q       <= wb_wreg_d;
      end
   end

   assign ex_alu_src    = ex_ctrl_q.alu_src;
   assign ex_reg_dst    = ex_ctrl_q.reg_dst;
   assign ex_alu_op     = ex_ctrl_q.alu_op;
   assign ex_rs         = ex_rs_q;
   assign ex_rt         = ex_rt_q;
   assign mem_mem_read  = mem_mem_read_q;
   assign mem_mem_write = mem_mem_write_q;
   assign mem_branch    = mem_branch_q;
   assign wb_reg_src    = wb_reg_src_q;
   assign wb_reg_write  = wb_reg_write_q;
   assign wb_wreg       = wb_wreg_q;

   ctrl_pipe_fwd_unit #(
      .REG_W(REG_W)
   ) u_fwd (
      .mem_reg_write(mem_reg_write_q),
      .mem_wreg     (mem_wreg_q),
      .wb_reg_write (wb_reg_write_q),
      .wb_wreg      (wb_wreg_q),
      .ex_rs        (ex_rs_q),
      .ex_rt        (ex_rt_q),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b)
   );

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed MIPS sequences with literal expectations, then
// randomized instruction streams (with occasional mid-run resets) compared every
// cycle against an instruction-level pipeline model.
module tb_ctrl_pipe;

   localparam int RW = 5;

   logic          clk, rst_n;
   logic          id_valid, id_reg_dst, id_alu_src, id_branch, id_mem_read, id_mem_write;
   logic          id_reg_src, id_reg_write;
   logic [1:0]    id_alu_op;
   logic [RW-1:0] id_rs, id_rt, id_rd;
   logic          mem_zero;
   logic          ex_alu_src, ex_reg_dst;
   logic [1:0]    ex_alu_op;
   logic [RW-1:0] ex_rs, ex_rt;
   logic          mem_mem_read, mem_mem_write, mem_branch;
   logic          wb_reg_src, wb_reg_write;
   logic [RW-1:0] wb_wreg;
   logic          pc_write, ifid_write, pc_src, ifid_flush;
   logic [1:0]    fwd_a, fwd_b;

   ctrl_pipe #(.REG_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_reg_dst(id_reg_dst),
      .id_alu_src(id_alu_src), .id_branch(id_branch), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_reg_src(id_reg_src), .id_reg_write(id_reg_write),
      .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .mem_zero(mem_zero), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
      .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .mem_branch(mem_branch), .wb_reg_src(wb_reg_src),
      .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg), .pc_write(pc_write),
      .ifid_write(ifid_write), .pc_src(pc_src), .ifid_flush(ifid_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          valid;
      logic          reg_dst, alu_src;
      logic [1:0]    alu_op;
      logic          branch, mem_read, mem_write, reg_src, reg_write;
      logic [RW-1:0] rs, rt, rd;
   } ins_t;

   int checks = 0;
   int errors = 0;

   // Model: which instruction occupies each stage (all-zero = bubble).
   ins_t          cur, m_ex, m_mem, m_wb;
   logic [RW-1:0] m_mem_wreg, m_wb_wreg;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic ins_t nop();
      return '0;
   endfunction
   function automatic ins_t lw(input int rs, input int rt);
      ins_t i = '0;
      i.valid = 1; i.alu_src = 1; i.mem_read = 1; i.reg_src = 1; i.reg_write = 1;
      i.rs = RW'(rs); i.rt = RW'(rt);
      return i;
   endfunction
   function automatic ins_t rtype(input int rs, input int rt, input int rd);
      ins_t i = '0;
      i.valid = 1; i.reg_dst = 1; i.alu_op = 2'b10; i.reg_write = 1;
      i.rs = RW'(rs); i.rt = RW'(rt); i.rd = RW'(rd);
      return i;
   endfunction
   function automatic ins_t beq(input int rs, input int rt);
      ins_t i = '0;
      i.valid = 1; i.branch = 1; i.alu_op = 2'b01;
      i.rs = RW'(rs); i.rt = RW'(rt);
      return i;
   endfunction
   function automatic ins_t sw(input int rs, input int rt);
      ins_t i = '0;
      i.valid = 1; i.alu_src = 1; i.mem_write = 1;
      i.rs = RW'(rs); i.rt = RW'(rt);
      return i;
   endfunction

   task automatic drive(input ins_t i, input logic z);
      cur          = i;
      id_valid     = i.valid;
      id_reg_dst   = i.reg_dst;
      id_alu_src   = i.alu_src;
      id_alu_op    = i.alu_op;
      id_branch    = i.branch;
      id_mem_read  = i.mem_read;
      id_mem_write = i.mem_write;
      id_reg_src   = i.reg_src;
      id_reg_write = i.reg_write;
      id_rs        = i.rs;
      id_rt        = i.rt;
      id_rd        = i.rd;
      mem_zero     = z;
   endtask

   function automatic logic m_taken();
      return m_mem.branch && mem_zero;
   endfunction

   // The instruction in ID reads the register a load in EX is about to fetch.
   function automatic logic m_load_use();
      return cur.valid && m_ex.mem_read && m_ex.rt != 0 &&
             (m_ex.rt == cur.rs || m_ex.rt == cur.rt);
   endfunction

   // Newest producer of src among the instructions ahead of EX.
   function automatic logic [1:0] m_fwd(input logic [RW-1:0] src);
      if (src == 0) return 2'b00;
      if (m_mem.reg_write && m_mem_wreg == src) return 2'b10;
      if (m_wb.reg_write && m_wb_wreg == src) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_ex = '0; m_mem = '0; m_wb = '0; m_mem_wreg = '0; m_wb_wreg = '0;
   endtask

   task automatic check_model();
      logic stall_go;
      stall_go = m_load_use() && !m_taken();
      chk("ex_alu_src", ex_alu_src, m_ex.alu_src);
      chk("ex_reg_dst", ex_reg_dst, m_ex.reg_dst);
      chk("ex_alu_op", ex_alu_op, m_ex.alu_op);
      chk("ex_rs", ex_rs, m_ex.rs);
      chk("ex_rt", ex_rt, m_ex.rt);
      chk("mem_mem_read", mem_mem_read, m_mem.mem_read);
      chk("mem_mem_write", mem_mem_write, m_mem.mem_write);
      chk("mem_branch", mem_branch, m_mem.branch);
      chk("wb_reg_src", wb_reg_src, m_wb.reg_src);
      chk("wb_reg_write", wb_reg_write, m_wb.reg_write);
      chk("wb_wreg", wb_wreg, m_wb_wreg);
      chk("pc_write", pc_write, !stall_go);
      chk("ifid_write", ifid_write, !stall_go);
      chk("pc_src", pc_src, m_taken());
      chk("ifid_flush", ifid_flush, m_taken());
      chk("fwd_a", fwd_a, m_fwd(m_ex.rs));
      chk("fwd_b", fwd_b, m_fwd(m_ex.rt));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ex"}, {ex_alu_src, ex_reg_dst, ex_alu_op, ex_rs, ex_rt}, 0);
      chk({tag, "_mem"}, {mem_mem_read, mem_mem_write, mem_branch}, 0);
      chk({tag, "_wb"}, {wb_reg_src, wb_reg_write, wb_wreg}, 0);
      chk({tag, "_pc_write"}, pc_write, 1);
      chk({tag, "_ifid_write"}, ifid_write, 1);
      chk({tag, "_pc_src_flush"}, {pc_src, ifid_flush}, 0);
      chk({tag, "_fwd"}, {fwd_a, fwd_b}, 0);
   endtask

   // Advance one clock: model moves every instruction one stage, then wait to the
   // negedge where the next stimulus is applied.
   task automatic step();
      logic taken, stall;
      @(posedge clk);
      taken = m_taken();
      stall = m_load_use();
      m_wb      = m_mem;
      m_wb_wreg = m_mem_wreg;
      if (taken) begin
         m_mem = '0; m_mem_wreg = '0;
      end else begin
         m_mem = m_ex; m_mem_wreg = m_ex.reg_dst ? m_ex.rd : m_ex.rt;
      end
      m_ex = (taken || stall || !cur.valid) ? '0 : cur;
      @(negedge clk);
   endtask

   // Drive, settle, compare against the model.
   task automatic cyc(input ins_t i, input logic z);
      drive(i, z);
      #1;
      check_model();
   endtask

   function automatic ins_t rand_ins();
      ins_t i = '0;
      int   k;
      i.valid = ($urandom_range(0, 9) != 0);
      k = $urandom_range(0, 5);
      case (k)
         0, 1: i = rtype($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         2:    i = lw($urandom_range(0, 3), $urandom_range(0, 3));
         3:    i = sw($urandom_range(0, 3), $urandom_range(0, 3));
         4:    i = beq($urandom_range(0, 3), $urandom_range(0, 3));
         default: begin
            i.reg_dst   = 1'($urandom); i.alu_src  = 1'($urandom); i.alu_op = 2'($urandom);
            i.branch    = 1'($urandom); i.mem_read = 1'($urandom);
            i.mem_write = 1'($urandom); i.reg_src  = 1'($urandom);
            i.reg_write = 1'($urandom);
            i.rs = RW'($urandom_range(0, 3)); i.rt = RW'($urandom_range(0, 3));
            i.rd = RW'($urandom_range(0, 3));
         end
      endcase
      if ($urandom_range(0, 9) == 0) i.valid = 1'b0;
      return i;
   endfunction

   initial begin
      rst_n = 1'b0;
      drive(nop(), 1'b0);
      model_reset();
      #12;
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);

      // Load-use: lw $2 then add $3,$2,$4.
      cyc(lw(1, 2), 0);                step();
      cyc(rtype(2, 4, 3), 0);
      chk("lu_stall_pc_write", pc_write, 0);
      chk("lu_stall_ifid_write", ifid_write, 0);
      step();
      cyc(rtype(2, 4, 3), 0);
      chk("lu_bubble_ex_alu_op", ex_alu_op, 2'b00);
      chk("lu_resume_pc_write", pc_write, 1);
      step();
      cyc(nop(), 0);
      chk("lu_add_ex_rs", ex_rs, 2);
      chk("lu_fwd_a_wb", fwd_a, 2'b01);
      step();

      // add $5,$1,$1 ; sub $6,$5,$5 back-to-back.
      cyc(rtype(1, 1, 5), 0);          step();
      cyc(rtype(5, 5, 6), 0);
      chk("rr_no_stall", pc_write, 1);
      step();
      cyc(nop(), 0);
      chk("rr_fwd_ab_mem", {fwd_a, fwd_b}, 4'b1010);
      step();

      // $7 written by both MEM and WB occupants; MEM wins.
      cyc(rtype(1, 1, 7), 0);          step();
      cyc(rtype(1, 1, 7), 0);          step();
      cyc(rtype(7, 0, 8), 0);          step();
      cyc(nop(), 0);
      chk("prio_fwd_a_mem", fwd_a, 2'b10);
      step();

      // Writes to $0 never forward.
      cyc(rtype(1, 1, 0), 0);          step();
      cyc(rtype(0, 0, 9), 0);          step();
      cyc(nop(), 0);
      chk("zero_fwd", {fwd_a, fwd_b}, 4'b0000);
      step();
      cyc(nop(), 0);                   step();

      // Taken beq in MEM while a load-use pair sits in EX/ID.
      cyc(beq(1, 1), 0);               step();
      cyc(lw(1, 2), 0);                step();
      cyc(rtype(2, 4, 3), 1);
      chk("br_pc_src", pc_src, 1);
      chk("br_ifid_flush", ifid_flush, 1);
      chk("br_pc_write", pc_write, 1);
      step();
      cyc(nop(), 0);
      chk("br_squash_ex", {ex_alu_src, ex_alu_op, ex_rt}, 0);
      chk("br_squash_mem_read", mem_mem_read, 0);
      step();

      // Not-taken beq: sw behind it reaches MEM and writes.
      cyc(beq(1, 2), 0);               step();
      cyc(sw(1, 3), 0);                step();
      cyc(nop(), 0);
      chk("nt_pc_src", pc_src, 0);
      step();
      cyc(nop(), 0);
      chk("nt_sw_mem_write", mem_mem_write, 1);
      step();

      // Taken beq: sw behind it is squashed.
      cyc(beq(1, 1), 0);               step();
      cyc(sw(1, 3), 0);                step();
      cyc(nop(), 1);                   step();
      cyc(nop(), 0);
      chk("tk_sw_squashed", mem_mem_write, 0);
      step();

      // Randomized stream with occasional asynchronous resets between edges.
      for (int n = 0; n < 1500; n++) begin
         cyc(rand_ins(), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            check_reset_outputs("rst");
            check_model();
            #1;
            rst_n = 1'b1;
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
